ifu_fetch: RTL and testbench

- Instruction fetch stage, directly upstream of the instruction decoder.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned words in a small prefetch FIFO and presents {ir, pc} to the decoder.
- Handles redirects from branch/jump resolution: flushes the FIFO and drops stale in-flight responses.

---
 rtl/ifu_pkg.sv | 10 +
 rtl/ifu_fifo.sv | 41 ++++
 rtl/ifu_fetch.sv | 90 +++++++++
 tb/tb_ifu_fetch.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants and types for the instruction fetch unit
// Contents: NOP_INSTR, fetch_pkt_t {ir, pc}, ifu_state_t {RUN, FLUSH}
package ifu_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fetch_pkt_t;
  typedef enum logic {RUN, FLUSH} ifu_state_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO of fetch_pkt_t with flush, occupancy count and full/empty
// Ports: clk, rst (sync, active-high), flush, push/din, pop/dout (head, combinational),
//        count, full, empty. DEPTH must be a power of two.
module ifu_fifo import ifu_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  fetch_pkt_t din,
  input  logic       pop,
  output fetch_pkt_t dout,
  output logic [AW:0] count,
  output logic       full,
  output logic       empty
);
  fetch_pkt_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic push_ok, pop_ok;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign pop_ok = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout = mem[rd];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (pop_ok) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage -- PC, in-order imem requests, prefetch FIFO, redirect flush
// Ports: clk, rst (sync, active-high); imem_req_valid/ready/addr; imem_resp_valid/data;
//        redirect_valid/pc; stall; ir, ir_pc, ir_valid to the decoder.
// Option: define IFU_PERF_CNT_EN to add perf_fetched / perf_dropped counters.
module ifu_fetch import ifu_pkg::*; #(
  parameter int IR_WIDTH = 32,
  parameter logic [IR_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [IR_WIDTH-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [IR_WIDTH-1:0] imem_resp_data,
  input  logic                redirect_valid,
  input  logic [IR_WIDTH-1:0] redirect_pc,
  input  logic                stall,
  output logic [IR_WIDTH-1:0] ir,
  output logic [IR_WIDTH-1:0] ir_pc,
  output logic                ir_valid
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_dropped
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [IR_WIDTH-1:0] pc;
  logic [CW-1:0] outstanding, outstanding_next, drop_cnt, drop_next, q_count, t_count;
  ifu_state_t state, state_next;
  fetch_pkt_t q_head, t_head;
  logic q_full, q_empty, t_full, t_empty;
  logic accept, pop, drop, keep;
  logic unused_ok;
  assign pop = ir_valid && !stall;
  // A slot freed by this cycle's pop counts as free, so issue keeps pace with a
  // non-stalling decoder; outstanding + count still never exceeds FIFO_DEPTH.
  assign imem_req_valid = !rst && (outstanding + q_count - CW'(pop)) < CW'(FIFO_DEPTH);
  assign imem_req_addr = pc;
  assign accept = imem_req_valid && imem_req_ready;
  // A response arriving with a redirect belongs to the old path.
  assign drop = imem_resp_valid && (state == FLUSH || redirect_valid);
  assign keep = imem_resp_valid && !drop;
  assign ir_valid = !q_empty;
  assign ir = ir_valid ? q_head.ir : NOP_INSTR;
  assign ir_pc = ir_valid ? q_head.pc : '0;
  assign unused_ok = ^{t_count, t_full, t_empty, q_full, t_head.ir};
  always_comb begin
    outstanding_next = outstanding + CW'(accept) - CW'(imem_resp_valid);
    drop_next = redirect_valid ? outstanding_next : drop_cnt - CW'(drop);
    state_next = (drop_next != '0) ? FLUSH : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      state <= RUN;
    end else begin
      pc <= redirect_valid ? {redirect_pc[IR_WIDTH-1:2], 2'b00} : accept ? pc + IR_WIDTH'(4) : pc;
      outstanding <= outstanding_next;
      drop_cnt <= drop_next;
      state <= state_next;
    end
  end
  // Request-PC tags for live (non-stale) requests, consumed by kept responses.
  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_tag (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(accept && !redirect_valid), .din('{ir: NOP_INSTR, pc: pc}),
    .pop(keep), .dout(t_head), .count(t_count), .full(t_full), .empty(t_empty)
  );
  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_prefetch (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(keep), .din('{ir: imem_resp_data, pc: t_head.pc}),
    .pop(pop), .dout(q_head), .count(q_count), .full(q_full), .empty(q_empty)
  );
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_dropped <= perf_dropped + 32'(drop);
    end
  end
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized self-checking bench for ifu_fetch against an in-order stream model
module tb_ifu_fetch;
  import ifu_pkg::*;
  localparam int D = 2;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready = 1;
  logic [31:0] imem_req_addr, imem_resp_data = 0, redirect_pc = 0, ir, ir_pc;
  logic imem_resp_valid = 0, redirect_valid = 0, stall = 0, ir_valid;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif
  always #5 clk = ~clk;
  ifu_fetch #(.IR_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );
  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  req_t mq[$];
  int tests = 0, fails = 0, cyc = 0, lat_lo = 1, lat_hi = 1, pops = 0, first_acc = -1, first_val = -1;
  logic [31:0] m_req_pc = 0, m_exp_pc = 0, m_fetched = 0, m_dropped = 0, hold_pc = 0, hold_ir = 0;
  bit prev_hold = 0, prev_redir = 0, prev_rst = 0, last_req_valid = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h00500093;
      32'h4: return 32'h00A00113;
      32'h8: return 32'h002081B3;
      32'hC: return 32'h0000006F;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc);
    bit acc, pop;
    redirect_valid = redir;
    redirect_pc = rpc;
    imem_resp_valid = !rst && mq.size() > 0 && mq[0].due <= cyc;
    imem_resp_data = imem_resp_valid ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
    #1;
    acc = imem_req_valid && imem_req_ready;
    pop = ir_valid && !stall;
    last_req_valid = imem_req_valid;
    if (rst) begin
      chk("rst_req_valid", imem_req_valid, 0);
      if (prev_rst) begin
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_ir", ir, NOP_INSTR);
        chk("rst_ir_pc", ir_pc, 0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 0);
        chk("rst_perf_dropped", perf_dropped, 0);
`endif
      end
      mq.delete();
      m_req_pc = 0; m_exp_pc = 0; m_fetched = 0; m_dropped = 0;
      first_acc = -1; first_val = -1;
    end else begin
      if (acc) chk("req_addr", imem_req_addr, m_req_pc);
      if (ir_valid) chk("ir_word", ir, mem_word(ir_pc));
      if (prev_redir) chk("valid_after_redirect", ir_valid, 0);
      if (prev_hold) begin
        chk("stall_hold_pc", ir_pc, hold_pc);
        chk("stall_hold_ir", ir, hold_ir);
      end
      if (pop && !redir) begin
        chk("ir_pc", ir_pc, m_exp_pc);
        m_exp_pc += 4;
        pops++;
      end
      if (pop) m_fetched++;
      if (ir_valid && first_val < 0) first_val = cyc;
      if (acc && first_acc < 0) first_acc = cyc;
      if (imem_resp_valid) begin
        if (mq[0].stale || redir) m_dropped++;
        mq.delete(0);
      end
      if (acc) begin
        mq.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_hi, lat_lo)), 1'b0});
        m_req_pc += 4;
      end
      if (redir) begin
        foreach (mq[i]) mq[i].stale = 1;
        m_req_pc = rpc & ~32'd3;
        m_exp_pc = m_req_pc;
      end
      if (mq.size() > D) chk("outstanding_cap", mq.size(), D);
    end
    prev_hold = !rst && ir_valid && stall && !redir;
    hold_pc = ir_pc;
    hold_ir = ir;
    prev_redir = redir && !rst;
    prev_rst = rst;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) step(0, 0);
    rst = 0;
  endtask

  initial begin
    int p0, waited, rst_cyc;
    @(negedge clk);
    do_reset();
    rst_cyc = cyc;
    repeat (2) step(0, 0);
    chk("first_req_cycle", first_acc, rst_cyc);
    stall = 1;
    repeat (5) step(0, 0);
    chk("first_valid_latency", first_val - first_acc, 2);
    chk("stall_req_blocked", last_req_valid, 0);
    chk("stall_ir", ir, 32'h00500093);
    chk("stall_ir_pc", ir_pc, 0);
    stall = 0;
    p0 = pops;
    repeat (4) step(0, 0);
    chk("throughput_4", pops - p0, 4);
    lat_lo = 3; lat_hi = 3;
    repeat (6) step(0, 0);
    waited = 0;
    while (!(mq.size() == 2 && mq[0].due > cyc && !mq[0].stale) && waited < 20) begin
      step(0, 0);
      waited++;
    end
    chk("wait_two_outstanding", waited < 20, 1);
    p0 = m_dropped;
    step(1, 32'h100);
    repeat (12) step(0, 0);
    chk("stale_dropped_2", m_dropped - p0, 2);
    chk("resume_at_0x100", m_exp_pc > 32'h100, 1);
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetched_dir", perf_fetched, m_fetched);
    chk("perf_dropped_dir", perf_dropped, m_dropped);
`endif
    lat_lo = 1; lat_hi = 1;
    repeat (6) step(0, 0);
    chk("resp_and_accept_ready", imem_req_valid && mq.size() > 0 && mq[0].due <= cyc, 1);
    step(1, 32'h203);
    chk("aligned_req_addr", imem_req_addr, 32'h200);
    repeat (8) step(0, 0);
    lat_lo = 1; lat_hi = 3;
    repeat (5) step(0, 0);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      stall = $urandom_range(9, 0) < 3;
      imem_req_ready = $urandom_range(9, 0) < 8;
      lat_lo = 1; lat_hi = 4;
      if ($urandom_range(99, 0) < 3)
        step(1, ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15, 0)) : $urandom);
      else
        step(0, 0);
    end
    stall = 0; imem_req_ready = 1; lat_lo = 1; lat_hi = 1;
    p0 = pops;
    repeat (30) step(0, 0);
    chk("drain_progress", (pops - p0) >= 20, 1);
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_dropped", perf_dropped, m_dropped);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
